// File: rtl/vend_session_arbiter.sv
// Round-robin session arbiter sharing one vending core between NREQ kiosks.
// Optional idle-session timeout is compiled in with `define VEND_ARB_TIMEOUT_EN.
module vend_session_arbiter #(
   parameter int NREQ    = 4,
   parameter int PRICE   = 15,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [4*NREQ-1:0]   amt_in,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     coin_reject,
   output logic [NREQ-1:0]     item_out,
   output logic [3:0]          change_out,
   output logic [NREQ-1:0]     refund_valid,
   output logic [4:0]          refund_amt,
   output logic [3:0]          vm_amt,
   output logic                vm_reset,
   input  logic                vm_item,
   input  logic [3:0]          vm_change
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [4:0] PRICE5 = 5'(PRICE);

   typedef enum logic [1:0] {IDLE, SESSION, DONE, ABORT} state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   pick_idx;
   logic [PW-1:0]   cand;
   logic            pick_found;
   logic [4:0]      credit;
   logic [3:0]      coin;
   logic            coin_legal;
   logic            coin_bad;
   logic            owner_req;
   logic            abort_req;
   logic            timeout_hit;

   // First requester at or after ptr, searching upward with wrap.
   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      cand       = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = PW'((int'(ptr) + i) % NREQ);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign owner_req  = req[owner];
   assign coin       = amt_in[4*int'(owner) +: 4];
   assign coin_legal = ((coin == 4'd5) || (coin == 4'd10)) && (credit < PRICE5);
   assign coin_bad   = (coin != 4'd0) && !coin_legal;

`ifdef VEND_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer;

   // Abort is decided in the coinless cycle that would bring the count to zero.
   assign timeout_hit = !coin_legal && (timer <= TW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         timer <= '0;
      end else if (state == IDLE) begin
         timer <= TW'(TIMEOUT);
      end else if (state == SESSION) begin
         if (coin_legal)
            timer <= TW'(TIMEOUT);
         else if (timer != '0)
            timer <= timer - TW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign abort_req = !owner_req || timeout_hit;
   assign vm_reset  = (state != SESSION);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pick_found) state_next = SESSION;
         SESSION: begin
            if (vm_item)
               state_next = DONE;
            else if (abort_req)
               state_next = ABORT;
         end
         DONE:    state_next = IDLE;
         ABORT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pulse outputs default low each cycle; an item delivery outranks an abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         ptr          <= '0;
         owner        <= '0;
         credit       <= '0;
         grant        <= '0;
         coin_reject  <= '0;
         item_out     <= '0;
         change_out   <= '0;
         refund_valid <= '0;
         refund_amt   <= '0;
         vm_amt       <= '0;
      end else begin
         state        <= state_next;
         coin_reject  <= '0;
         item_out     <= '0;
         change_out   <= '0;
         refund_valid <= '0;
         refund_amt   <= '0;
         vm_amt       <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant  <= NREQ'(1) << pick_idx;
                  owner  <= pick_idx;
                  credit <= '0;
               end
            end
            SESSION: begin
               if (vm_item) begin
                  item_out   <= grant;
                  change_out <= vm_change;
               end else if (abort_req) begin
                  refund_valid <= grant;
                  refund_amt   <= credit;
               end else if (coin_legal) begin
                  vm_amt <= coin;
                  credit <= credit + {1'b0, coin};
               end else if (coin_bad) begin
                  coin_reject <= grant;
               end
            end
            DONE, ABORT: begin
               grant <= '0;
               ptr   <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
            end
            default: grant <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Self-checking bench for vend_session_arbiter: vector table plus scoreboard queue.
// Timeout sequence follows `VEND_ARB_TIMEOUT_EN.
module tb_vend_session_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] amt_in;
   logic        vm_item;
   logic [3:0]  vm_change;
   logic [3:0]  grant, coin_reject, item_out, change_out, refund_valid, vm_amt;
   logic [4:0]  refund_amt;
   logic        vm_reset;

   int total  = 0;
   int passed = 0;

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  rq;
      logic [15:0] amt;
      logic        itm;
      logic [3:0]  chg;
      logic [3:0]  g;
      logic [3:0]  rj;
      logic [3:0]  io;
      logic [3:0]  co;
      logic [3:0]  rv;
      logic [4:0]  ra;
      logic [3:0]  va;
      logic        vr;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   vend_session_arbiter #(.NREQ(4), .PRICE(15), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .req(req), .amt_in(amt_in),
      .grant(grant), .coin_reject(coin_reject), .item_out(item_out),
      .change_out(change_out), .refund_valid(refund_valid),
      .refund_amt(refund_amt), .vm_amt(vm_amt), .vm_reset(vm_reset),
      .vm_item(vm_item), .vm_change(vm_change)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(string n, logic rst, logic [3:0] rq, logic [15:0] amt,
                               logic itm, logic [3:0] chg, logic [3:0] g, logic [3:0] rj,
                               logic [3:0] io, logic [3:0] co, logic [3:0] rv,
                               logic [4:0] ra, logic [3:0] va, logic vr);
      vec_t v;
      v.name = n; v.rst = rst; v.rq = rq; v.amt = amt; v.itm = itm; v.chg = chg;
      v.g = g; v.rj = rj; v.io = io; v.co = co; v.rv = rv; v.ra = ra; v.va = va; v.vr = vr;
      return v;
   endfunction

   task automatic checkField(input string n, input string f, input logic [4:0] act,
                             input logic [4:0] req_v);
      total++;
      if (act === req_v)
         passed++;
      else
         $display("[TB] FAIL %s.%s actual=%0h required=%0h", n, f, act, req_v);
   endtask

   task automatic applyStimulus(input vec_t v);
      reset     = v.rst;
      req       = v.rq;
      amt_in    = v.amt;
      vm_item   = v.itm;
      vm_change = v.chg;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput();
      vec_t e;
      if (exp_q.size() == 0) begin
         total++;
         $display("[TB] FAIL scoreboard actual=empty required=entry");
      end else begin
         e = exp_q.pop_front();
         checkField(e.name, "grant",        {1'b0, grant},        {1'b0, e.g});
         checkField(e.name, "coin_reject",  {1'b0, coin_reject},  {1'b0, e.rj});
         checkField(e.name, "item_out",     {1'b0, item_out},     {1'b0, e.io});
         checkField(e.name, "change_out",   {1'b0, change_out},   {1'b0, e.co});
         checkField(e.name, "refund_valid", {1'b0, refund_valid}, {1'b0, e.rv});
         checkField(e.name, "refund_amt",   refund_amt,           e.ra);
         checkField(e.name, "vm_amt",       {1'b0, vm_amt},       {1'b0, e.va});
         checkField(e.name, "vm_reset",     {4'b0, vm_reset},     {4'b0, e.vr});
      end
   endtask

   task automatic runVec(input vec_t v);
      applyStimulus(v);
      checkOutput();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; req = '0; amt_in = '0; vm_item = 1'b0; vm_change = '0;

      //                name     rst rq    amt       itm chg   g     rj    io    co    rv    ra    va    vr
      vecs.push_back(mk("rst0",  1, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("rst1",  1, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      // Basic purchase by kiosk 0, then ptr=1 shown by kiosk 1 winning over kiosk 0.
      vecs.push_back(mk("a_gnt", 0, 4'h1, 16'h0000, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("a_c5",  0, 4'h1, 16'h0005, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h5, 0));
      vecs.push_back(mk("a_c10", 0, 4'h1, 16'h000A, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'hA, 0));
      vecs.push_back(mk("a_itm", 0, 4'h1, 16'h0000, 1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("a_idl", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("a_ptr", 0, 4'h3, 16'h0000, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("a_drp", 0, 4'h1, 16'h0000, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 5'd0, 4'h0, 1));
      vecs.push_back(mk("a_end", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      // Kiosk 1 owner: illegal coin, non-owner coins ignored, coin after credit 20.
      vecs.push_back(mk("c_rst", 1, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("c_gnt", 0, 4'h2, 16'h0000, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("c_c3",  0, 4'h2, 16'h0030, 0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("c_c10", 0, 4'h2, 16'h35A5, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'hA, 0));
      vecs.push_back(mk("c_c20", 0, 4'h2, 16'h00A0, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'hA, 0));
      vecs.push_back(mk("c_ovr", 0, 4'h2, 16'h0050, 0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("c_itm", 0, 4'h2, 16'h0000, 1, 4'h5, 4'h2, 4'h0, 4'h2, 4'h5, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("c_end", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      // Refund on req drop, then item and drop together: item wins.
      vecs.push_back(mk("d_rst", 1, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("d_gnt", 0, 4'h8, 16'h0000, 0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("d_c10", 0, 4'h8, 16'hA000, 0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'hA, 0));
      vecs.push_back(mk("d_drp", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 5'd10, 4'h0, 1));
      vecs.push_back(mk("d_idl", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("d_gn2", 0, 4'h8, 16'h0000, 0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("d_pre", 0, 4'h0, 16'h0000, 1, 4'h2, 4'h8, 4'h0, 4'h8, 4'h2, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("d_end", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      // Kiosks 0 and 2 requesting continuously: 0, 2, 0 with two cycles between.
      vecs.push_back(mk("b_rst", 1, 4'h5, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("b_g0",  0, 4'h5, 16'h0000, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("b_i0",  0, 4'h5, 16'h0000, 1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("b_x0",  0, 4'h5, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("b_g2",  0, 4'h5, 16'h0000, 0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("b_i2",  0, 4'h5, 16'h0000, 1, 4'h3, 4'h4, 4'h0, 4'h4, 4'h3, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("b_x2",  0, 4'h5, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("b_g0b", 0, 4'h5, 16'h0000, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("b_drp", 0, 4'h4, 16'h0000, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 5'd0, 4'h0, 1));
      vecs.push_back(mk("b_end", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      // Reset mid-session with credit 5 (ptr was 1): no refund, ptr back to 0.
      vecs.push_back(mk("e_gnt", 0, 4'h4, 16'h0000, 0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("e_c5",  0, 4'h4, 16'h0500, 0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h5, 0));
      vecs.push_back(mk("e_rst", 1, 4'h4, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));
      vecs.push_back(mk("e_ptr", 0, 4'h3, 16'h0000, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      vecs.push_back(mk("e_drp", 0, 4'h2, 16'h0000, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 5'd0, 4'h0, 1));
      vecs.push_back(mk("e_end", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));

      foreach (vecs[i]) runVec(vecs[i]);

      // Idle session after one coin of 5 by kiosk 1 (ptr is 1 here).
      runVec(mk("t_gnt", 0, 4'h2, 16'h0000, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      runVec(mk("t_c5",  0, 4'h2, 16'h0050, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h5, 0));
`ifdef VEND_ARB_TIMEOUT_EN
      for (int k = 1; k < 16; k++)
         runVec(mk($sformatf("t_idle%0d", k), 0, 4'h2, 16'h0000, 0, 4'h0,
                   4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      runVec(mk("t_tmo", 0, 4'h2, 16'h0000, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 5'd5, 4'h0, 1));
`else
      for (int k = 1; k <= 100; k++)
         runVec(mk($sformatf("t_idle%0d", k), 0, 4'h2, 16'h0000, 0, 4'h0,
                   4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 0));
      runVec(mk("t_drp", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 5'd5, 4'h0, 1));
`endif
      runVec(mk("t_end", 0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'h0, 1));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
